regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 integer register file. It shares the register file's single synchronous write port among NREQ producers (ALU, load unit, CSR unit) using round-robin with valid/ready handshakes, and drives RegWrite/rd/WriteData from registers. It also tracks which architectural registers have writes in flight and tells the decode stage when rs1 or rs2 must stall (RAW) or when a new destination cannot be issued (WAW).

## Interface
- NREQ, 3, number of write-back requesters (2..4); index 0 = ALU, 1 = LSU, 2 = CSR
- XLEN, 32, data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- req_valid  in  NREQ  requester i has a write-back pending
- req_rd  in  5*NREQ  destination of requester i (slice i*5+:5)
- req_data  in  XLEN*NREQ  write data of requester i (slice i*XLEN+:XLEN)
- req_ready  out  NREQ  one-hot/zero grant; transfer when req_valid[i] && req_ready[i]
- RegWrite  out  1  register-file write enable (registered)
- rd  out  5  register-file write address (registered)
- WriteData  out  XLEN  register-file write data (registered)
- sb_set_valid  in  1  decode issues an instruction that writes sb_set_rd
- sb_set_rd  in  5  destination being issued
- sb_set_ready  out  1  issue accepted (combinational)
- rs1, rs2  in  5 each  source registers being decoded
- raw_stall  out  1  rs1 or rs2 has an in-flight write (combinational)
- busy  out  32  scoreboard vector, bit 0 always 0

## Operation
- Round-robin pointer ptr (width clog2(NREQ)), reset 0. Search order ptr, ptr+1, ..., wrapping modulo NREQ; the first i with req_valid[i] gets req_ready[i]=1, all others 0. At most one grant per cycle.
- On a transfer from requester g: ptr <= (g+1) mod NREQ. No transfer: ptr holds.
- Output stage: on transfer with req_rd != 0: RegWrite<=1, rd<=req_rd[g], WriteData<=req_data[g]. On transfer with req_rd == 0: the request is consumed and RegWrite<=0 (x0 writes are discarded). No transfer: RegWrite<=0; rd and WriteData hold their last values.
- The output stage never back-pressures. Exactly one grant is issued per cycle whenever any req_valid is high.
- Scoreboard busy[31:1], reset 0, busy[0] tied 0.
  - Set: sb_set_valid && sb_set_ready && sb_set_rd != 0 sets busy[sb_set_rd] at the edge.
  - Clear: when RegWrite==1 in a cycle, busy[rd] clears at the end of that cycle, which is the same edge on which the register file stores the data.
  - Same register set and cleared on the same edge: set wins.
- sb_set_ready = !(sb_set_rd != 0 && busy[sb_set_rd] && !(RegWrite && rd == sb_set_rd)). WAW is blocked unless the older write retires this cycle. sb_set_rd == 0 is always ready.
- raw_stall = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]). There is no forwarding; a register is readable in the cycle after its busy bit clears.
- Requesters must hold req_valid, req_rd and req_data stable until the transfer completes. A violation is outside this block's contract.

## Timing
- Reset (async assert, sync release to clk): req_ready=0 while in reset, RegWrite=0, rd=0, WriteData=0, busy=0, ptr=0. A write held in the output stage is dropped when reset asserts.
- req_ready, sb_set_ready and raw_stall are combinational from current inputs and state. There is no combinational path from req_* to RegWrite/rd/WriteData.
- Latency:
  - Transfer accepted at edge E0.
  - RegWrite=1 during cycle E0..E1.
  - Register file written and busy cleared at E1.
  - raw_stall for that register drops in cycle E1..E2.
- Throughput: one write per cycle sustained. With all NREQ requesters continuously valid, each is served once every NREQ cycles.

## Test plan
- Reset: assert rst_n=0 mid-stream with RegWrite=1, busy[5]=1 -> RegWrite=0, rd=0, WriteData=0, busy=0 immediately; after release, first grant goes to requester 0.
- Round-robin fairness: all three requesters valid for 6 cycles (rd=1,2,3, data 0xA,0xB,0xC) -> grants 0,1,2,0,1,2; RegWrite high for 6 consecutive cycles with rd 1,2,3,1,2,3.
- Latency and scoreboard: issue sb_set rd=7; LSU writes rd=7 data 0xDEADBEEF accepted at E0 -> RegWrite=1 with rd=7 in cycle E0..E1; busy[7]=1 until E1; raw_stall for rs1=7 high through E0..E1, low in E1..E2.
- x0 handling: ALU request with rd=0 data 0x1234 -> req_ready=1, RegWrite stays 0; sb_set rd=0 -> sb_set_ready=1, busy unchanged; rs1=rs2=0 -> raw_stall=0.
- WAW and set-wins: busy[9]=1, sb_set rd=9 with no retire -> sb_set_ready=0. Same cycle as RegWrite=1 with rd=9 -> sb_set_ready=1 and busy[9] remains 1 after the edge.
- Pointer wrap and idle hold: only requester 2 valid, then only requester 0 valid -> grant 2, then ptr=0 and grant 0. With no requests for 3 cycles -> ptr holds, RegWrite=0, and rd/WriteData keep their last values.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file write port,
// plus a busy scoreboard that reports RAW stalls and blocks WAW issue.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 RegWrite,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      WriteData,
    input  logic                 sb_set_valid,
    input  logic [4:0]           sb_set_rd,
    output logic                 sb_set_ready,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 raw_stall,
    output logic [31:0]          busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [31:0]     busy_q, busy_d;

    logic [PW-1:0]   gidx;
    logic            found;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gidx  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            logic [PW-1:0] idx;
            idx = PW'((32'(ptr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign xfer     = found && rst_n;
    assign sel_rd   = req_rd[32'(gidx)*5 +: 5];
    assign sel_data = req_data[32'(gidx)*XLEN +: XLEN];

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gidx] = 1'b1;
    end

    always_comb begin
        ptr_d      = ptr_q;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (xfer) begin
            ptr_d = PW'((32'(gidx) + 1) % NREQ);
            // x0 writes are consumed but leave the write stage untouched
            if (sel_rd != 5'd0) begin
                regwrite_d = 1'b1;
                rd_d       = sel_rd;
                wdata_d    = sel_data;
            end
        end
    end

    assign sb_set_ready = !((sb_set_rd != 5'd0) && busy_q[sb_set_rd] &&
                            !(regwrite_q && (rd_q == sb_set_rd)));

    // Clear first so a same-edge set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (regwrite_q) busy_d[rd_q] = 1'b0;
        if (sb_set_valid && sb_set_ready && (sb_set_rd != 5'd0))
            busy_d[sb_set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign raw_stall = ((rs1 != 5'd0) && busy_q[rs1]) ||
                       ((rs2 != 5'd0) && busy_q[rs2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign rd        = rd_q;
    assign WriteData = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write-back
// latency, scoreboard set/clear/WAW behaviour and asynchronous reset.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 RegWrite;
    logic [4:0]           rd;
    logic [XLEN-1:0]      WriteData;
    logic                 sb_set_valid;
    logic [4:0]           sb_set_rd;
    logic                 sb_set_ready;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 raw_stall;
    logic [31:0]          busy;

    int unsigned n_chk;
    int unsigned n_err;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .RegWrite     (RegWrite),
        .rd           (rd),
        .WriteData    (WriteData),
        .sb_set_valid (sb_set_valid),
        .sb_set_rd    (sb_set_rd),
        .sb_set_ready (sb_set_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .raw_stall    (raw_stall),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic [4:0] r,
                           input logic [31:0] d);
        req_valid[i]        = v;
        req_rd[i*5 +: 5]    = r;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_rd       = '0;
        req_data     = '0;
        sb_set_valid = 1'b0;
        sb_set_rd    = '0;
        rs1          = '0;
        rs2          = '0;

        // power-on reset with requests pending: no grant while in reset
        set_req(0, 1'b1, 5'd1, 32'hA);
        #2;
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_regwrite", 32'(RegWrite), 32'h0);
        check_eq("rst_rd", 32'(rd), 32'h0);
        check_eq("rst_wdata", WriteData, 32'h0);
        check_eq("rst_busy", busy, 32'h0);
        set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // round robin: all three valid for six cycles
        set_req(0, 1'b1, 5'd1, 32'hA);
        set_req(1, 1'b1, 5'd2, 32'hB);
        set_req(2, 1'b1, 5'd3, 32'hC);
        for (int unsigned c = 0; c < 6; c++) begin
            #1;
            check_eq("rr_grant", 32'(req_ready), 32'(1 << (c % 3)));
            tick();
            check_eq("rr_regwrite", 32'(RegWrite), 32'h1);
            check_eq("rr_rd", 32'(rd), c % 3 + 1);
            check_eq("rr_wdata", WriteData, 32'hA + c % 3);
        end
        req_valid = '0;

        // scoreboard set for x7, then LSU retires x7
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd7;
        #1;
        check_eq("sb7_ready", 32'(sb_set_ready), 32'h1);
        tick();
        sb_set_valid = 1'b0;
        check_eq("sb7_regwrite_idle", 32'(RegWrite), 32'h0);
        check_eq("sb7_busy", busy, 32'h80);
        rs1 = 5'd7;
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        check_eq("lat_stall_pre", 32'(raw_stall), 32'h1);
        check_eq("lat_grant", 32'(req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 5'd7, 32'hDEADBEEF);
        check_eq("lat_regwrite", 32'(RegWrite), 32'h1);
        check_eq("lat_rd", 32'(rd), 32'h7);
        check_eq("lat_wdata", WriteData, 32'hDEADBEEF);
        check_eq("lat_busy_e0", busy, 32'h80);
        check_eq("lat_stall_e0", 32'(raw_stall), 32'h1);
        tick();
        check_eq("lat_regwrite_e1", 32'(RegWrite), 32'h0);
        check_eq("lat_busy_e1", busy, 32'h0);
        check_eq("lat_stall_e1", 32'(raw_stall), 32'h0);
        rs1 = 5'd0;

        // x0: request consumed, no write, scoreboard untouched
        set_req(0, 1'b1, 5'd0, 32'h1234);
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd0;
        #1;
        check_eq("x0_grant", 32'(req_ready), 32'h1);
        check_eq("x0_sb_ready", 32'(sb_set_ready), 32'h1);
        check_eq("x0_stall", 32'(raw_stall), 32'h0);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        sb_set_valid = 1'b0;
        check_eq("x0_regwrite", 32'(RegWrite), 32'h0);
        check_eq("x0_busy", busy, 32'h0);

        // WAW block, then set-wins against a same-edge retire of x9
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd9;
        #1;
        check_eq("waw_first_ready", 32'(sb_set_ready), 32'h1);
        tick();
        check_eq("waw_busy", busy, 32'h200);
        check_eq("waw_blocked", 32'(sb_set_ready), 32'h0);
        set_req(2, 1'b1, 5'd9, 32'h99);
        #1;
        check_eq("waw_grant", 32'(req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 5'd9, 32'h99);
        check_eq("waw_regwrite", 32'(RegWrite), 32'h1);
        check_eq("waw_rd", 32'(rd), 32'h9);
        check_eq("waw_retire_ready", 32'(sb_set_ready), 32'h1);
        tick();
        sb_set_valid = 1'b0;
        check_eq("setwins_busy", busy, 32'h200);
        check_eq("setwins_regwrite", 32'(RegWrite), 32'h0);

        // pointer wrap: requester 2 then ptr back to 0
        set_req(2, 1'b1, 5'd4, 32'h44);
        #1;
        check_eq("wrap_grant2", 32'(req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 5'd4, 32'h44);
        check_eq("wrap_rd4", 32'(rd), 32'h4);
        check_eq("wrap_wdata44", WriteData, 32'h44);
        set_req(0, 1'b1, 5'd5, 32'h55);
        set_req(1, 1'b1, 5'd6, 32'h66);
        #1;
        check_eq("wrap_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_eq("wrap_rd5", 32'(rd), 32'h5);
        check_eq("wrap_wdata55", WriteData, 32'h55);

        // idle: write stage holds address/data, pointer holds at 1
        for (int unsigned c = 0; c < 3; c++) begin
            tick();
            check_eq("idle_regwrite", 32'(RegWrite), 32'h0);
            check_eq("idle_rd", 32'(rd), 32'h5);
            check_eq("idle_wdata", WriteData, 32'h55);
            check_eq("idle_ready", 32'(req_ready), 32'h0);
        end
        set_req(0, 1'b1, 5'd1, 32'hA);
        set_req(1, 1'b1, 5'd6, 32'h66);
        set_req(2, 1'b1, 5'd4, 32'h44);
        #1;
        check_eq("idle_ptr_hold", 32'(req_ready), 32'h2);

        // build RegWrite=1 with busy[5] set, then reset mid-stream
        set_req(0, 1'b0, 5'd1, 32'hA);
        set_req(2, 1'b0, 5'd4, 32'h44);
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd5;
        #1;
        check_eq("pre_rst_sb_ready", 32'(sb_set_ready), 32'h1);
        tick();
        sb_set_valid = 1'b0;
        req_valid    = '0;
        check_eq("pre_rst_regwrite", 32'(RegWrite), 32'h1);
        check_eq("pre_rst_rd", 32'(rd), 32'h6);
        check_eq("pre_rst_busy", busy, 32'h220);
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check_eq("mid_rst_regwrite", 32'(RegWrite), 32'h0);
        check_eq("mid_rst_rd", 32'(rd), 32'h0);
        check_eq("mid_rst_wdata", WriteData, 32'h0);
        check_eq("mid_rst_busy", busy, 32'h0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("mid_rst_hold_regwrite", 32'(RegWrite), 32'h0);
        check_eq("mid_rst_hold_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_eq("post_rst_regwrite", 32'(RegWrite), 32'h1);
        check_eq("post_rst_rd", 32'(rd), 32'h1);
        check_eq("post_rst_wdata", WriteData, 32'hA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
